// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W  = 64;
    localparam int DEFAULT_DATA_W  = 64;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        IFU = 1'b0,
        LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between fetch and load/store requesters.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   req_ifu,
    input  logic   req_lsu,
    output logic   gnt_valid,
    output owner_t gnt
);

    owner_t last_grant;

    always_comb begin
        gnt_valid = en && (req_ifu || req_lsu);
        gnt       = LSU;
        if (req_ifu && req_lsu) begin
            gnt = (last_grant == IFU) ? LSU : IFU;
        end else if (req_ifu) begin
            gnt = IFU;
        end
    end

    // Reset value LSU so that the first tie after reset goes to the fetch side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= LSU;
        end else if (gnt_valid) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port, one
// transaction at a time, with a sticky timeout when memory stops responding.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    owner_t            owner_q;
    owner_t            gnt;
    logic              gnt_valid;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              resp_hit;
    logic              timeout_hit;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .en        ((state_q == IDLE) && !rst),
        .req_ifu   (ifu_req_valid),
        .req_lsu   (lsu_req_valid),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign resp_hit    = !rst && (state_q == WAIT) && mem_resp_valid;
    assign timeout_hit = (state_q == WAIT) && !mem_resp_valid
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ISSUE;
            ISSUE:   if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_resp_valid || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and response strobes are gated by rst so nothing leaks while it is held.
    assign ifu_req_ready  = gnt_valid && (gnt == IFU);
    assign lsu_req_ready  = gnt_valid && (gnt == LSU);
    assign mem_req_valid  = !rst && (state_q == ISSUE);
    assign ifu_resp_valid = resp_hit && (owner_q == IFU);
    assign lsu_resp_valid = resp_hit && (owner_q == LSU);
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= IFU;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt_valid) begin
                owner_q <= gnt;
                addr_q  <= (gnt == IFU) ? ifu_addr : lsu_addr;
                wen_q   <= (gnt == LSU) && lsu_wen;
                wdata_q <= (gnt == LSU) ? lsu_wdata : '0;
                wmask_q <= (gnt == LSU) ? lsu_wmask : '0;
            end
            if ((state_q == ISSUE) && mem_req_ready) begin
                cnt_q <= '0;
            end else if ((state_q == WAIT) && (cnt_q != CNT_W'(TIMEOUT))) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter; the bench plays the memory
// and predicts grants from the round-robin rule.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    bit last_was_ifu;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .timeout_err    (timeout_err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request; the winner comes from the round-robin rule.
    task automatic request(input bit iv, input bit lv, input logic [63:0] ia,
                           input logic [63:0] la, input logic lw, input logic [63:0] lwd,
                           input logic [7:0] lm, output bit own_ifu);
        own_ifu = (iv && lv) ? !last_was_ifu : iv;
        last_was_ifu = own_ifu;
        ifu_req_valid = iv; lsu_req_valid = lv;
        ifu_addr = ia; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
        #1;
        check("req_ready", {ifu_req_ready, lsu_req_ready}, {own_ifu, !own_ifu});
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_addr  = {$urandom, $urandom};
        lsu_addr  = {$urandom, $urandom};
        lsu_wen   = ~lsu_wen;
        lsu_wdata = {$urandom, $urandom};
        lsu_wmask = ~lsu_wmask;
    endtask

    // Acts as memory for one granted transaction, starting in its ISSUE cycle.
    task automatic serve(input bit own_ifu, input logic [63:0] addr, input logic wen,
                         input logic [7:0] wm, input logic [63:0] wd, input int acc,
                         input int rdly, input bit spur, input logic [63:0] rdata);
        logic [137:0] exp_f;
        exp_f = {1'b1, addr, own_ifu ? 1'b0 : wen, own_ifu ? 8'h00 : wm, own_ifu ? 64'h0 : wd};
        for (int k = 0; k <= acc; k++) begin
            mem_req_ready  = (k == acc);
            mem_resp_valid = spur;
            #1;
            check("issue_fields", {mem_req_valid, mem_addr, mem_wen, mem_wmask,
                  own_ifu ? 64'h0 : mem_wdata}, exp_f);
            check("issue_no_resp", {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 0);
            @(negedge clk);
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        for (int r = 0; r < rdly; r++) begin
            #1;
            check("wait_quiet", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 0);
            @(negedge clk);
        end
        mem_resp_valid = 1'b1; mem_rdata = rdata;
        #1;
        check("resp_valid", {ifu_resp_valid, lsu_resp_valid}, {own_ifu, !own_ifu});
        if (own_ifu) check("ifu_rdata", ifu_rdata, rdata);
        else if (!wen) check("lsu_rdata", lsu_rdata, rdata);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("resp_once", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          own;
        bit          iv, lv, lw;
        logic [63:0] ia, la, lwd;
        logic [7:0]  lm;
        int          rose;

        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        last_was_ifu = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
              mem_req_valid, timeout_err}, 0);
        check("reset_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Both requesters valid from the first cycle after reset: strict alternation.
        for (int i = 0; i < 4; i++) begin
            ia = 64'h1000 + 64'(i); la = 64'h2000 + 64'(i); lwd = 64'hA5A5 + 64'(i);
            request(1'b1, 1'b1, ia, la, 1'b0, lwd, 8'h0F, own);
            serve(own, own ? ia : la, 1'b0, 8'h0F, lwd, 0, 0, 1'b0, {$urandom, $urandom});
        end

        // Fetch only, response on the second WAIT cycle.
        request(1'b1, 1'b0, 64'h8000_0000, 64'h0, 1'b1, 64'hFFFF, 8'hFF, own);
        serve(own, 64'h8000_0000, 1'b1, 8'hFF, 64'hFFFF, 0, 1, 1'b0, 64'h0000_0413_0000_0093);

        // Store held off by memory for five cycles.
        request(1'b0, 1'b1, 64'h0, 64'h8000_1000, 1'b1, 64'h1234_5678_8765_4321, 8'hFF, own);
        serve(own, 64'h8000_1000, 1'b1, 8'hFF, 64'h1234_5678_8765_4321, 5, 2, 1'b0, 64'hDEAD);

        // Spurious memory responses in IDLE and in ISSUE.
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            #1;
            check("idle_spurious", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 0);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        request(1'b0, 1'b1, 64'h0, 64'h4040, 1'b0, 64'h0, 8'h03, own);
        serve(own, 64'h4040, 1'b0, 8'h03, 64'h0, 2, 0, 1'b1, 64'hC0FFEE);

        // Randomized traffic with random memory timing.
        for (int n = 0; n < 24; n++) begin
            iv = 1'($urandom); lv = 1'($urandom);
            if (!iv && !lv) iv = 1'b1;
            ia = {$urandom, $urandom}; la = {$urandom, $urandom};
            lw = 1'($urandom); lwd = {$urandom, $urandom}; lm = 8'($urandom);
            request(iv, lv, ia, la, lw, lwd, lm, own);
            serve(own, own ? ia : la, lw, lm, lwd, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom), {$urandom, $urandom});
        end

        // Memory never answers: error must rise after exactly 255 WAIT cycles.
        request(1'b1, 1'b0, 64'h9000, 64'h0, 1'b0, 64'h0, 8'h0, own);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rose = 0;
        for (int i = 1; i <= 400 && rose == 0; i++) begin
            #1;
            if (timeout_err) rose = i;
            else @(negedge clk);
        end
        check("timeout_edge", rose, 256);
        check("timeout_idle", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 0);
        request(1'b1, 1'b1, 64'h9100, 64'h9200, 1'b1, 64'h77, 8'h81, own);
        serve(own, own ? 64'h9100 : 64'h9200, 1'b1, 8'h81, 64'h77, 1, 1, 1'b0, 64'h55);
        check("timeout_sticky", timeout_err, 1'b1);

        // Reset while waiting drops the transaction and clears the error.
        request(1'b0, 1'b1, 64'h0, 64'hA000, 1'b0, 64'h0, 8'hF0, own);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1; mem_resp_valid = 1'b1;
        #1;
        check("rst_wait_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        @(negedge clk);
        #1;
        check("rst_applied", {ifu_resp_valid, lsu_resp_valid, mem_req_valid, timeout_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_resp", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        last_was_ifu = 1'b0;
        request(1'b1, 1'b1, 64'hB000, 64'hB100, 1'b0, 64'h0, 8'h0, own);
        serve(own, own ? 64'hB000 : 64'hB100, 1'b0, 8'h0, 64'h0, 0, 0, 1'b0, 64'h1234);
        check("post_rst_err", timeout_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
